// File: rtl/bsg_counter_overflow_sched_if.sv
// Bus bundle for the overflow scheduler: request/accept handshake, the
// count controls and the status outputs. Widths are derived here from the
// same two parameters the scheduler uses, so both sides always agree.
interface bsg_counter_overflow_sched_if #(
    parameter int els_p     = 4,
    parameter int max_val_p = 10000000
);
    localparam int ptr_width_lp = $clog2(max_val_p + 1);
    localparam int id_width_lp  = (els_p > 1) ? $clog2(els_p) : 1;

    logic [els_p-1:0]              v_i;
    logic [els_p*ptr_width_lp-1:0] start_i;
    logic [els_p-1:0]              yumi_o;
    logic                          en_i;
    logic                          abort_i;
    logic [els_p-1:0]              done_o;
    logic                          busy_o;
    logic [id_width_lp-1:0]        grant_id_o;
    logic [ptr_width_lp-1:0]       count_o;

    // Requester/client side.
    modport master (
        output v_i,
        output start_i,
        output en_i,
        output abort_i,
        input  yumi_o,
        input  done_o,
        input  busy_o,
        input  grant_id_o,
        input  count_o
    );

    // Scheduler side.
    modport slave (
        input  v_i,
        input  start_i,
        input  en_i,
        input  abort_i,
        output yumi_o,
        output done_o,
        output busy_o,
        output grant_id_o,
        output count_o
    );
endinterface

// File: rtl/bsg_counter_overflow_sched.sv
// Round-robin timeout scheduler sharing one overflow counter among els_p
// requesters. IDLE grants one requester and loads its (clamped) start value;
// RUN counts up to max_val_p, then pulses the owner's done line and returns
// to IDLE. Abort cancels the running timeout silently.
module bsg_counter_overflow_sched #(
    parameter int els_p     = 4,
    parameter int max_val_p = 10000000
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    bsg_counter_overflow_sched_if.slave    bus
);
    localparam int ptr_width_lp = $clog2(max_val_p + 1);
    localparam int id_width_lp  = (els_p > 1) ? $clog2(els_p) : 1;

    localparam logic [ptr_width_lp-1:0] max_val_lp = ptr_width_lp'(max_val_p);
    // Requester count in the one-bit-wider index arithmetic used for wrapping.
    localparam logic [id_width_lp:0]    els_lp     = (id_width_lp + 1)'(els_p);

    typedef enum logic {
        IDLE_S = 1'b0,
        RUN_S  = 1'b1
    } state_e;

    state_e                  state_q,    state_d;
    logic [ptr_width_lp-1:0] count_q,    count_d;
    logic [id_width_lp-1:0]  grant_id_q, grant_id_d;
    logic [id_width_lp-1:0]  rr_ptr_q,   rr_ptr_d;

    logic                    found;
    logic [id_width_lp-1:0]  winner;
    logic [id_width_lp:0]    scan;
    logic [id_width_lp:0]    ptr_next;
    logic [ptr_width_lp-1:0] start_sel;
    logic [ptr_width_lp-1:0] start_clamped;
    logic                    accept;
    logic                    overflow;
    logic [els_p-1:0]        yumi_vec;
    logic [els_p-1:0]        done_vec;

    logic [ptr_width_lp-1:0] start_lane [els_p];

    // Unpack the start values into one lane per requester.
    for (genvar gi = 0; gi < els_p; gi++) begin : g_lane
        assign start_lane[gi] = bus.start_i[gi*ptr_width_lp +: ptr_width_lp];
    end

    // Round-robin pick: scan from the pointer upward, wrapping at els_p.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = '0;
        for (int i = 0; i < els_p; i++) begin
            scan = {1'b0, rr_ptr_q} + (id_width_lp + 1)'(i);
            if (scan >= els_lp) begin
                scan = scan - els_lp;
            end
            if (!found && bus.v_i[scan[id_width_lp-1:0]]) begin
                found  = 1'b1;
                winner = scan[id_width_lp-1:0];
            end
        end
    end

    // Winner's start value, clamped so the count can never pass max_val_p.
    always_comb begin
        start_sel     = start_lane[winner];
        start_clamped = (start_sel > max_val_lp) ? max_val_lp : start_sel;
        ptr_next      = {1'b0, winner} + (id_width_lp + 1)'(1);
        if (ptr_next >= els_lp) begin
            ptr_next = '0;
        end
    end

    // Next-state logic: accept in IDLE; abort > overflow > enable in RUN.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        accept     = 1'b0;
        overflow   = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (found) begin
                    accept     = 1'b1;
                    count_d    = start_clamped;
                    grant_id_d = winner;
                    rr_ptr_d   = ptr_next[id_width_lp-1:0];
                    state_d    = RUN_S;
                end
            end
            RUN_S: begin
                if (bus.abort_i) begin
                    count_d = '0;
                    state_d = IDLE_S;
                end else if (count_q == max_val_lp) begin
                    overflow = 1'b1;
                    count_d  = '0;
                    state_d  = IDLE_S;
                end else if (bus.en_i) begin
                    count_d = count_q + ptr_width_lp'(1);
                end
            end
            default: begin
                state_d = IDLE_S;
            end
        endcase
    end

    // State, counter, owner and round-robin pointer registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE_S;
            count_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // One-hot accept and done decode; accept is masked while reset is high.
    for (genvar gi = 0; gi < els_p; gi++) begin : g_decode
        assign yumi_vec[gi] = accept && !reset_i && (winner == id_width_lp'(gi));
        assign done_vec[gi] = overflow && (grant_id_q == id_width_lp'(gi));
    end

    assign bus.yumi_o     = yumi_vec;
    assign bus.done_o     = done_vec;
    assign bus.busy_o     = (state_q == RUN_S);
    assign bus.grant_id_o = grant_id_q;
    assign bus.count_o    = count_q;

endmodule

// File: tb/tb_bsg_counter_overflow_sched.sv
// Bench for the overflow scheduler with els_p=4, max_val_p=10. A table of
// grant vectors runs back to back; expected done pulses (owner and cycle)
// go into a queue at accept time and are matched by a negedge monitor.
// Hand-written sequences cover enable freeze, abort and reset mid-run.
module tb_bsg_counter_overflow_sched;
    localparam int ELS  = 4;
    localparam int MAXV = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bsg_counter_overflow_sched_if #(.els_p(ELS), .max_val_p(MAXV)) bus ();

    bsg_counter_overflow_sched #(.els_p(ELS), .max_val_p(MAXV)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] done;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] v;
        logic [3:0] start;
        logic [3:0] exp_yumi;
        int         exp_id;
        int         exp_count;
        int         lat;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic [3:0] s);
        for (int k = 0; k < ELS; k++) begin
            bus.start_i[k*4 +: 4] = s;
        end
    endtask

    // Present a request, wait (bounded) for the accept, check it, step past it.
    task automatic do_accept(input logic [3:0] v, input logic [3:0] s, input logic [3:0] ey,
                             input bit hold, input string nm, output int t);
        bus.v_i = v;
        set_start(s);
        #1;
        for (int k = 0; k < 60 && bus.yumi_o == 4'b0; k++) begin
            tick();
            #1;
        end
        chk({nm, " yumi"}, 32'(bus.yumi_o), 32'(ey));
        t = cyc;
        tick();
        if (!hold) bus.v_i = 4'b0;
        $display("accept %s: v=%b start=%0d yumi=%b at cycle %0d", nm, v, s, ey, t);
    endtask

    // Scoreboard: every done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done_o !== 4'b0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected done: got %b expected none (cycle %0d)", bus.done_o, cyc);
            end else begin
                e = sb.pop_front();
                chk("done onehot", 32'(bus.done_o), 32'(e.done));
                chk("done cycle", cyc, e.cyc);
                $display("done %b at cycle %0d", bus.done_o, cyc);
            end
        end
    end

    initial begin
        int t;
        int prev_done;

        vecs[0] = '{4'b1111, 4'd9,  4'b0001, 0, 9,  2};
        vecs[1] = '{4'b1111, 4'd9,  4'b0010, 1, 9,  2};
        vecs[2] = '{4'b1111, 4'd9,  4'b0100, 2, 9,  2};
        vecs[3] = '{4'b1111, 4'd9,  4'b1000, 3, 9,  2};
        vecs[4] = '{4'b1111, 4'd9,  4'b0001, 0, 9,  2};
        vecs[5] = '{4'b0100, 4'd15, 4'b0100, 2, 10, 1};
        vecs[6] = '{4'b0001, 4'd0,  4'b0001, 0, 0,  11};
        vecs[7] = '{4'b1001, 4'd3,  4'b1000, 3, 3,  8};
        vecs[8] = '{4'b1010, 4'd10, 4'b0010, 1, 10, 1};
        vecs[9] = '{4'b0011, 4'd2,  4'b0001, 0, 2,  9};

        bus.v_i     = 4'b0;
        bus.start_i = '0;
        bus.en_i    = 1'b0;
        bus.abort_i = 1'b0;

        // Reset state, including accept masked during reset.
        #1;
        bus.v_i = 4'b1111;
        #1;
        chk("reset count", 32'(bus.count_o), 0);
        chk("reset busy", 32'(bus.busy_o), 0);
        chk("reset done", 32'(bus.done_o), 0);
        chk("reset grant", 32'(bus.grant_id_o), 0);
        chk("reset yumi", 32'(bus.yumi_o), 0);
        bus.v_i = 4'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        bus.en_i = 1'b1;

        // Table: back-to-back grants with v_i held between vectors.
        prev_done = 0;
        for (int i = 0; i < 10; i++) begin
            do_accept(vecs[i].v, vecs[i].start, vecs[i].exp_yumi, 1'b1, $sformatf("vec%0d", i), t);
            sb.push_back('{vecs[i].exp_yumi, t + vecs[i].lat});
            if (i > 0) chk("b2b spacing", t, prev_done + 1);
            chk("load count", 32'(bus.count_o), 32'(vecs[i].exp_count));
            chk("load busy", 32'(bus.busy_o), 1);
            chk("grant id", 32'(bus.grant_id_o), 32'(vecs[i].exp_id));
            prev_done = t + vecs[i].lat;
        end
        bus.v_i = 4'b0;
        for (int k = 0; k < 60 && bus.busy_o; k++) tick();
        chk("table drain busy", 32'(bus.busy_o), 0);
        tick();

        // Basic timeout: count 7,8,9,10 then idle with count 0.
        do_accept(4'b0010, 4'd7, 4'b0010, 1'b0, "basic", t);
        sb.push_back('{4'b0010, t + 4});
        for (int k = 0; k < 4; k++) begin
            chk("basic count", 32'(bus.count_o), 32'(7 + k));
            tick();
        end
        chk("basic end count", 32'(bus.count_o), 0);
        chk("basic end busy", 32'(bus.busy_o), 0);

        // Enable freeze: three frozen cycles push done from t+6 to t+9.
        do_accept(4'b0100, 4'd5, 4'b0100, 1'b0, "freeze", t);
        sb.push_back('{4'b0100, t + 9});
        chk("freeze count5", 32'(bus.count_o), 5);
        tick();
        chk("freeze count6", 32'(bus.count_o), 6);
        bus.en_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("freeze hold", 32'(bus.count_o), 6);
        end
        bus.en_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("freeze resume", 32'(bus.count_o), 32'(7 + k));
        end
        tick();
        chk("freeze end busy", 32'(bus.busy_o), 0);

        // Abort at count 8: no done, idle next cycle.
        do_accept(4'b1000, 4'd7, 4'b1000, 1'b0, "abort8", t);
        tick();
        chk("abort8 count", 32'(bus.count_o), 8);
        bus.abort_i = 1'b1;
        #1;
        chk("abort8 done", 32'(bus.done_o), 0);
        tick();
        bus.abort_i = 1'b0;
        chk("abort8 busy", 32'(bus.busy_o), 0);
        chk("abort8 cleared", 32'(bus.count_o), 0);

        // Abort coincident with overflow: still no done.
        do_accept(4'b0001, 4'd9, 4'b0001, 1'b0, "abort10", t);
        tick();
        chk("abort10 count", 32'(bus.count_o), 10);
        bus.abort_i = 1'b1;
        #1;
        chk("abort10 done", 32'(bus.done_o), 0);
        tick();
        bus.abort_i = 1'b0;
        chk("abort10 busy", 32'(bus.busy_o), 0);
        chk("abort10 cleared", 32'(bus.count_o), 0);

        // Asynchronous reset mid-run at count 6.
        do_accept(4'b0010, 4'd2, 4'b0010, 1'b0, "rstmid", t);
        for (int k = 0; k < 4; k++) tick();
        chk("rstmid count", 32'(bus.count_o), 6);
        #2;
        rst = 1'b1;
        bus.v_i = 4'b1111;
        #1;
        chk("rstmid async count", 32'(bus.count_o), 0);
        chk("rstmid async busy", 32'(bus.busy_o), 0);
        chk("rstmid async done", 32'(bus.done_o), 0);
        chk("rstmid async yumi", 32'(bus.yumi_o), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        do_accept(4'b1111, 4'd1, 4'b0001, 1'b0, "post-reset", t);
        sb.push_back('{4'b0001, t + 10});
        for (int k = 0; k < 30 && bus.busy_o; k++) tick();
        chk("post-reset busy", 32'(bus.busy_o), 0);
        tick();
        tick();
        chk("scoreboard empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bsg_counter_overflow_sched.md
# bsg_counter_overflow_sched

Round-robin timeout scheduler that shares a single overflow counter among `els_p` requesters. Each requester posts a start value. The block grants one requester at a time, loads the counter with that value, and counts up to `max_val_p`. On overflow it pulses that requester's done line and returns to idle. It sits between client timeout/watchdog logic and the shared overflow-counter datapath, and owns all sequencing of that counter's set, enable and clear.

## Interface
Parameters:
- `els_p`, default 4: number of requesters; must be ≥1.
- `max_val_p`, default 10000000: overflow threshold of the shared counter.
- `ptr_width_lp`, derived: `clog2(max_val_p+1)` (24 at the default).
- `id_width_lp`, derived: `max(1, clog2(els_p))`.

Ports:
- `clk_i`, in, 1: single clock, rising edge.
- `reset_i`, in, 1: reset, asynchronous and active-high.
- `v_i`, in, `els_p`: request valid, one bit per requester.
- `start_i`, in, `els_p*ptr_width_lp`: packed start values; requester k uses bits `[k*ptr_width_lp +: ptr_width_lp]`.
- `yumi_o`, out, `els_p`: one-hot accept pulse; the request is consumed in the cycle `yumi_o` is high.
- `en_i`, in, 1: count enable; low freezes the count in RUN.
- `abort_i`, in, 1: cancels the active timeout.
- `done_o`, out, `els_p`: one-hot, one-cycle pulse to the owning requester when its timeout expires.
- `busy_o`, out, 1: high when state is RUN.
- `grant_id_o`, out, `id_width_lp`: index of the current or last owner.
- `count_o`, out, `ptr_width_lp`: shared counter value.

## Operation
States: IDLE and RUN.

IDLE:
- `yumi_o` is asserted combinationally for the single winner among `v_i`.
- The winner is chosen round-robin. The highest priority goes to the index after the last granted one; after reset, index 0 has highest priority.
- On accept:
  - count ← `start_i[winner]`, clamped to `max_val_p` if larger.
  - `grant_id` ← winner.
  - the round-robin pointer advances past the winner.
  - state ← RUN.
- With no `v_i`, the state, count and pointer hold.

RUN:
- `yumi_o` is 0; new requests wait.
- If `abort_i`: count ← 0, state ← IDLE, no `done_o`. `abort_i` has priority over overflow and over `en_i`.
- Else if count == `max_val_p` (overflow):
  - `done_o[grant_id]` is high this cycle.
  - count ← 0, state ← IDLE.
  - Overflow ends the timeout regardless of `en_i`.
- Else if `en_i`: count ← count+1.
- Else: count holds.

Arithmetic and outputs:
- Count is unsigned, `ptr_width_lp` bits, and never exceeds `max_val_p`. Wrap-around past `max_val_p` is impossible by construction.
- `abort_i` and `en_i` are ignored in IDLE.
- `done_o` is decoded only from the RUN state and the overflow compare. It is never asserted in IDLE or in the cycle after reset.

## Timing
Reset values (asynchronous, effective immediately on `reset_i` high):
- state IDLE, count 0, `grant_id_o` 0, RR pointer 0.
- `busy_o` 0, `done_o` 0.
- `yumi_o` is 0 while `reset_i` is high.

Latency and throughput:
- Accept in cycle t. In cycle t+1, `count_o` = start and `busy_o` = 1.
- With `en_i` held high, `done_o` fires in cycle t+1+(`max_val_p`−start), i.e. `max_val_p`−start+1 cycles after accept.
- Each cycle with `en_i` low in RUN (non-overflow) adds one cycle of latency.
- The done cycle itself cannot accept a request. The earliest next `yumi_o` is at done+1. Back-to-back spacing is therefore (`max_val_p`−start+2) cycles.

Boundary conditions:
- Start ≥ `max_val_p`: `done_o` fires at t+1.
- Start = 0: full `max_val_p`+1 cycle timeout.
- `abort_i` in the same cycle as overflow: no `done_o`; return to IDLE.
- Reset mid-RUN: the timeout is dropped silently, with no `done_o`.
- A requester that drops `v_i` before its grant is simply not granted.
- `start_i` is sampled only in the `yumi_o` cycle.

## Test plan
Use `els_p`=4 and `max_val_p`=10 for all scenarios.

- **Basic timeout:** `v_i`=0001, start=7, `en_i`=1. Required: `yumi_o`=0001 at t, `count_o` 7,8,9,10, `done_o`=0001 at t+4, `count_o`=0 and `busy_o`=0 at t+5.
- **Round-robin:** `v_i`=1111 held, all starts=9. Required: grant order 0,1,2,3,0; `done_o` every 3 cycles, one-hot to the matching index; next `yumi_o` exactly 1 cycle after each done.
- **Clamp and zero:** start=15 gives done at t+1. Start=0 gives done at t+11.
- **Enable freeze:** start=5, `en_i` low for 3 cycles mid-run. Required: `count_o` holds during the freeze; done at t+9 instead of t+6.
- **Abort:** `abort_i` at count=8 gives no done and IDLE next cycle. `abort_i` coincident with count=10 gives no done.
- **Async reset mid-run:** assert `reset_i` off-edge at count=6. Required: `count_o`=0, `busy_o`=0 and `done_o`=0 immediately; after release, the first grant goes to requester 0 when `v_i`=1111.
